// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding,
// default data width and iteration-counter sizing.
package div_seq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ITER_CNT_W = $clog2(DATA_W_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Counter width able to hold the value data_w (one count per quotient bit).
  function automatic int iter_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift {R,Q} left by one, trial-subtract
// the divisor magnitude and keep the difference only when it is non-negative.
module div_seq_step
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W:0]   r_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W:0]   r_o,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W+1:0]        shifted;
  logic signed [DATA_W+2:0] trial;
  logic                     ge;

  always_comb begin
    shifted = {r_i, q_i[DATA_W-1]};
    // One spare sign bit above the shifted remainder so the borrow is visible.
    trial   = signed'({1'b0, shifted}) - signed'({3'b000, d_i});
    ge      = (trial >= 0);
    r_o     = ge ? trial[DATA_W:0] : shifted[DATA_W:0];
    q_o     = {q_i[DATA_W-2:0], ge};
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider (MIPS DIV): quotient to lo, remainder to hi.
// Magnitudes are divided by restoring shift-subtract, then signs are restored.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     div_control,
  input  logic signed [DATA_W-1:0] A,
  input  logic signed [DATA_W-1:0] B,
  output logic signed [DATA_W-1:0] hi,
  output logic signed [DATA_W-1:0] lo,
  output logic                     div_stop,
  output logic                     div_zero,
  output logic                     busy
);

  localparam int CNT_W = iter_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  // Two's-complement magnitude; the most negative value maps to its unsigned twin.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? negate(v) : v;
  endfunction

  div_state_e               state_q, state_d;
  logic [DATA_W:0]          r_q, r_d;
  logic [DATA_W-1:0]        q_q, q_d;
  logic [DATA_W-1:0]        d_q, d_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     sgnq_q, sgnq_d;
  logic                     sgnr_q, sgnr_d;
  logic                     zero_q, zero_d;
  logic signed [DATA_W-1:0] hi_q, hi_d;
  logic signed [DATA_W-1:0] lo_q, lo_d;
  logic                     stop_q, stop_d;
  logic                     dz_q, dz_d;
  logic                     busy_q, busy_d;

  logic [DATA_W:0]          step_r;
  logic [DATA_W-1:0]        step_q;

  div_seq_step #(.DATA_W(DATA_W)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    // Done/zero flags are registered off the DONE state, so they show one edge later.
    stop_d  = (state_q == ST_DONE);
    dz_d    = (state_q == ST_DONE) && zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (div_control) begin
          if (B == '0) begin
            zero_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            zero_d  = 1'b0;
            r_d     = '0;
            q_d     = magnitude(A);
            d_d     = magnitude(B);
            cnt_d   = '0;
            sgnq_d  = A[DATA_W-1] ^ B[DATA_W-1];
            sgnr_d  = A[DATA_W-1];
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        lo_d    = sgnq_q ? negate(q_q) : q_q;
        hi_d    = sgnr_q ? negate(r_q[DATA_W-1:0]) : r_q[DATA_W-1:0];
        state_d = ST_DONE;
      end
      ST_DONE: begin
        zero_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      stop_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      stop_q  <= stop_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_stop = stop_q;
  assign div_zero = dz_q;
  assign busy     = busy_q;

endmodule
